// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader driving the instruction memory IO port.
// Takes a length-prefixed, little-endian byte stream (4-byte word count, then
// the words), writes each assembled word to consecutive addresses starting
// at BASE_ADDR, and reports ACK/NAK with one status byte on the UART TX side.
//
// Handshakes: rx_valid is a one-cycle pulse and rx_data is sampled only on
// that cycle, with no backpressure toward the receiver. tx_valid rises with
// tx_data and both hold steady until a cycle with tx_ready=1, which completes
// the transfer.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 32768,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  NAK_BYTE  = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        io_sel,
  output logic        we,
  output logic [31:0] addr_io,
  output logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  // The word index is one bit wider than the index range. That lets it
  // reach MAX_WORDS after the last write of a full-size image.
  localparam int IW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {IDLE, LEN, DATA, RESP, FIN} state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] word_idx;
  logic [31:0]   len;
  logic [23:0]   word_buf;
  logic          ack_path;

  logic [31:0] len_next;
  logic [31:0] word_idx_ext;

  assign len_next     = {rx_data, len[31:8]};
  assign word_idx_ext = 32'(word_idx);
  assign state_dbg    = state;

  // Main FSM: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      len      <= 32'd0;
      word_buf <= 24'd0;
      ack_path <= 1'b0;
      io_sel   <= 1'b0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
      addr_io  <= BASE_ADDR;
      din      <= 32'd0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN;
            busy     <= 1'b1;
            io_sel   <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= 2'd0;
            word_idx <= '0;
            len      <= 32'd0;
            word_buf <= 24'd0;
          end
        end
        LEN: begin
          if (rx_valid) begin
            len      <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_next == 32'd0) begin
                state    <= RESP;
                tx_valid <= 1'b1;
                tx_data  <= ACK_BYTE;
                ack_path <= 1'b1;
              end else if (len_next > 32'(MAX_WORDS)) begin
                state    <= RESP;
                tx_valid <= 1'b1;
                tx_data  <= NAK_BYTE;
                ack_path <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          // The write cycle of the last word closes the load. Any other
          // write cycle still accepts a byte for the next word.
          if (we && word_idx_ext == len) begin
            state    <= RESP;
            tx_valid <= 1'b1;
            tx_data  <= ACK_BYTE;
            ack_path <= 1'b1;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                we       <= 1'b1;
                din      <= {rx_data, word_buf};
                addr_io  <= BASE_ADDR + (word_idx_ext << 2);
                word_idx <= word_idx + IW'(1);
              end
            endcase
          end
        end
        RESP: begin
          if (tx_ready) begin
            state    <= FIN;
            tx_valid <= 1'b0;
            io_sel   <= 1'b0;
            busy     <= 1'b0;
            done     <= ack_path;
            err      <= ~ack_path;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader. Expected memory writes are queued as
// {addr, data} when the driver sends a word. A monitor pops one entry for
// every we pulse and compares it.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        io_sel;
  logic        we;
  logic [31:0] addr_io;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];

  instr_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .io_sel(io_sel),
    .we(we), .addr_io(addr_io), .din(din), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver tasks
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] l, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(l[8*i +: 8]);
      if (i < 3) tick(gap);
    end
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] w, input int gap);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (i < 3) tick(gap);
    end
    check("we_latency", 64'(we), 64'd1);
  endtask

  task automatic wait_tx(input string tag);
    int k;
    k = 0;
    while (tx_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_tx_valid"}, 64'(tx_valid), 64'd1);
  endtask

  task automatic finish_resp(input logic [7:0] exp_byte, input int hold);
    for (int i = 0; i < hold; i++) begin
      check("tx_hold_valid", 64'(tx_valid), 64'd1);
      check("tx_hold_data", 64'(tx_data), 64'(exp_byte));
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("fin_tx_valid", 64'(tx_valid), 64'd0);
    check("fin_io_sel", 64'(io_sel), 64'd0);
    check("fin_busy", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: every we pulse must match the next queued write
  always @(posedge clk) begin
    #2;
    if (we === 1'b1) begin
      n_writes++;
      check("we_io_sel", 64'(io_sel), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'(we), 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(addr_io), {32'd0, e[63:32]});
        check("wr_data", 64'(din), {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    int w0;
    // Reset then idle
    tick(2);
    rst = 1'b0;
    tick(10);
    check("rst_io_sel", 64'(io_sel), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_addr", 64'(addr_io), 64'd0);

    // Two-word image, gaps of 5 cycles
    w0 = n_writes;
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_io_sel", 64'(io_sel), 64'd1);
    send_len(32'd2, 5);
    tick(5);
    send_word(32'h0, 32'hDEADBEEF, 5);
    tick(5);
    send_word(32'h4, 32'h12345678, 5);
    tick();
    check("final_wr_to_tx", 64'(tx_valid), 64'd1);
    check("ack_byte", 64'(tx_data), 64'hAA);
    finish_resp(8'hAA, 3);
    check("gap_done", 64'(done), 64'd1);
    check("gap_err", 64'(err), 64'd0);
    check("gap_nwrites", 64'(n_writes - w0), 64'd2);
    check("gap_q_empty", 64'(exp_q.size()), 64'd0);
    tick(3);

    // Same image back-to-back
    w0 = n_writes;
    pulse_start();
    check("b2b_done_cleared", 64'(done), 64'd0);
    send_len(32'd2, 0);
    send_word(32'h0, 32'hDEADBEEF, 0);
    send_word(32'h4, 32'h12345678, 0);
    wait_tx("b2b");
    check("b2b_ack", 64'(tx_data), 64'hAA);
    finish_resp(8'hAA, 1);
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_nwrites", 64'(n_writes - w0), 64'd2);
    tick(3);

    // Oversized length 32769 -> NAK
    w0 = n_writes;
    pulse_start();
    send_len(32'd32769, 1);
    check("nak_latency", 64'(tx_valid), 64'd1);
    check("nak_byte", 64'(tx_data), 64'h55);
    finish_resp(8'h55, 2);
    check("nak_err", 64'(err), 64'd1);
    check("nak_done", 64'(done), 64'd0);
    check("nak_nwrites", 64'(n_writes - w0), 64'd0);
    tick(3);

    // Maximum legal length 32768 is accepted into DATA
    pulse_start();
    send_len(32'd32768, 0);
    tick();
    check("max_len_no_tx", 64'(tx_valid), 64'd0);
    check("max_len_state", 64'(state_dbg), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);

    // Zero length -> immediate ACK, no writes
    w0 = n_writes;
    pulse_start();
    check("zero_err_cleared", 64'(err), 64'd0);
    send_len(32'd0, 0);
    check("zero_latency", 64'(tx_valid), 64'd1);
    check("zero_ack", 64'(tx_data), 64'hAA);
    finish_resp(8'hAA, 1);
    check("zero_done", 64'(done), 64'd1);
    check("zero_nwrites", 64'(n_writes - w0), 64'd0);
    tick(3);

    // Start mid-load is ignored
    w0 = n_writes;
    pulse_start();
    send_len(32'd2, 0);
    send_word(32'h0, 32'hCAFEF00D, 1);
    pulse_start();
    check("mid_start_busy", 64'(busy), 64'd1);
    send_word(32'h4, 32'h0BADC0DE, 1);
    wait_tx("mid");
    finish_resp(8'hAA, 1);
    check("mid_nwrites", 64'(n_writes - w0), 64'd2);
    check("mid_q_empty", 64'(exp_q.size()), 64'd0);
    tick(3);

    // Reset mid-word, then a fresh one-word load
    w0 = n_writes;
    pulse_start();
    send_len(32'd1, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_io_sel", 64'(io_sel), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_we", 64'(we), 64'd0);
    send_byte(8'h33);
    send_byte(8'h44);
    tick(3);
    check("midrst_nwrites", 64'(n_writes - w0), 64'd0);
    pulse_start();
    send_len(32'd1, 0);
    send_word(32'h0, 32'hA5C3_0F81 + 32'($urandom_range(0, 255)), 2);
    wait_tx("rst_reload");
    finish_resp(8'hAA, 1);
    check("reload_done", 64'(done), 64'd1);
    check("reload_nwrites", 64'(n_writes - w0), 64'd1);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    tick(3);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
